button_conditioner: RTL and testbench

//   Upstream input stage for the counter/display FSM. Takes N raw push-button inputs and

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 163 ++++++++++++++++
 rtl/button_conditioner.sv | 42 ++++
 tb/tb_button_conditioner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_pkg : shared channel-state encoding and default timing constants     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package btn_pkg;

    typedef logic [2:0] chan_state_t;

    localparam chan_state_t ST_IDLE      = 3'd0;
    localparam chan_state_t ST_DEB_PRESS = 3'd1;
    localparam chan_state_t ST_HELD      = 3'd2;
    localparam chan_state_t ST_LONG      = 3'd3;
    localparam chan_state_t ST_DEB_REL   = 3'd4;

    // Defaults assume a 100 MHz clock.
    localparam int DEB_10MS     = 1_000_000;
    localparam int LONG_1S      = 100_000_000;
    localparam int REPEAT_200MS = 20_000_000;

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_channel : synchroniser, debounce FSM and hold/repeat timing, 1 button |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_10MS,
    parameter int LONG_CYCLES   = LONG_1S,
    parameter int REPEAT_CYCLES = REPEAT_200MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  c_DEB_MAX   = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] c_HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  c_REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              r_sync1, r_sync2;
    chan_state_t       r_state, w_state;
    logic [DEB_W-1:0]  r_deb_cnt, w_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt, w_rep_cnt;
    logic              r_level, w_level;
    logic              r_press, w_press;
    logic              r_release, w_release;
    logic              r_long, w_long;
    logic              r_repeat, w_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_state    <= ST_IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_state    <= w_state;
            r_deb_cnt  <= w_deb_cnt;
            r_hold_cnt <= w_hold_cnt;
            r_rep_cnt  <= w_rep_cnt;
            r_level    <= w_level;
            r_press    <= w_press;
            r_release  <= w_release;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_deb_cnt  = r_deb_cnt;
        w_hold_cnt = r_hold_cnt;
        w_rep_cnt  = r_rep_cnt;
        w_level    = r_level;
        w_press    = 1'b0;
        w_release  = 1'b0;
        w_long     = 1'b0;
        w_repeat   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_level = 1'b0;
                if (r_sync2) begin
                    w_state   = ST_DEB_PRESS;
                    w_deb_cnt = DEB_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (!r_sync2) begin
                    w_state   = ST_IDLE;
                    w_deb_cnt = '0;
                end else if (r_deb_cnt == c_DEB_MAX) begin
                    w_state    = ST_HELD;
                    w_level    = 1'b1;
                    w_press    = 1'b1;
                    w_deb_cnt  = '0;
                    w_hold_cnt = '0;
                    w_rep_cnt  = '0;
                end else begin
                    w_deb_cnt = r_deb_cnt + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state   = ST_DEB_REL;
                    w_deb_cnt = DEB_W'(1);
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state    = ST_LONG;
                    w_hold_cnt = c_HOLD_MAX;
                    w_rep_cnt  = '0;
                    w_long     = 1'b1;
                    w_repeat   = 1'b1;
                end else begin
                    w_hold_cnt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (!r_sync2) begin
                    w_state   = ST_DEB_REL;
                    w_deb_cnt = DEB_W'(1);
                end else if (r_rep_cnt == c_REP_LAST) begin
                    w_rep_cnt = '0;
                    w_repeat  = 1'b1;
                end else begin
                    w_rep_cnt = r_rep_cnt + REP_W'(1);
                end
            end
            ST_DEB_REL: begin
                // A saturated hold counter identifies which held state to resume.
                if (r_sync2) begin
                    w_state   = (r_hold_cnt == c_HOLD_MAX) ? ST_LONG : ST_HELD;
                    w_deb_cnt = '0;
                end else if (r_deb_cnt == c_DEB_MAX) begin
                    w_state    = ST_IDLE;
                    w_level    = 1'b0;
                    w_release  = 1'b1;
                    w_deb_cnt  = '0;
                    w_hold_cnt = '0;
                    w_rep_cnt  = '0;
                end else begin
                    w_deb_cnt = r_deb_cnt + DEB_W'(1);
                end
            end
            default: begin
                w_state    = ST_IDLE;
                w_level    = 1'b0;
                w_deb_cnt  = '0;
                w_hold_cnt = '0;
                w_rep_cnt  = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_conditioner : N independent debounced buttons with event pulses   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = 3,
    parameter int DEB_CYCLES    = DEB_10MS,
    parameter int LONG_CYCLES   = LONG_1S,
    parameter int REPEAT_CYCLES = REPEAT_200MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_long    (btn_long[g]),
            .o_repeat  (btn_repeat[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_conditioner : directed tables, corner sequences, random + model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_button_conditioner;

    localparam int N    = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_repeat  (btn_repeat)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: run-length view of the synchronised input.
    bit           m_s1[N], m_s2[N], m_lvl[N], m_long_done[N];
    int           m_run[N], m_held[N], m_rep[N];
    logic [N-1:0] e_level, e_press, e_release, e_long, e_repeat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int i = 0; i < N; i++) begin
            bit s;
            if (rst) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_long_done[i] = 0;
                m_run[i] = 0; m_held[i] = 0; m_rep[i] = 0;
            end else begin
                s = m_s2[i];
                if (!m_lvl[i]) begin
                    if (s) begin
                        m_run[i]++;
                        if (m_run[i] == DEB + 1) begin
                            m_lvl[i] = 1; e_press[i] = 1'b1;
                            m_run[i] = 0; m_held[i] = 0; m_rep[i] = 0; m_long_done[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end else if (!s) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_lvl[i] = 0; e_release[i] = 1'b1;
                        m_run[i] = 0; m_held[i] = 0; m_rep[i] = 0; m_long_done[i] = 0;
                    end
                end else if (m_run[i] > 0) begin
                    m_run[i] = 0;  // glitch absorbed; timing resumes next cycle
                end else if (!m_long_done[i]) begin
                    m_held[i]++;
                    if (m_held[i] == LONG) begin
                        m_long_done[i] = 1; m_rep[i] = 0;
                        e_long[i] = 1'b1; e_repeat[i] = 1'b1;
                    end
                end else begin
                    m_rep[i]++;
                    if (m_rep[i] == REP) begin
                        m_rep[i] = 0; e_repeat[i] = 1'b1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            e_level[i] = m_lvl[i];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("model", {btn_level, btn_press, btn_release, btn_long, btn_repeat},
              {e_level, e_press, e_release, e_long, e_repeat});
    endtask

    task automatic do_reset();
        raw = '0;
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", {btn_level, btn_press, btn_release, btn_long, btn_repeat}, 32'd0);
        rst = 1'b0;
        cyc = -1;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic         lvl;
        logic         prs;
        logic         rel;
    } vec_t;

    vec_t vt[20];

    initial begin
        int press_at, long_n, long_at, rel_at, rel_n, low_n, press_n;
        logic [N-1:0] pv, rv;
        int rq[$];
        int exp3[4];
        int exp4[5];
        int bounce[6];

        for (int k = 0; k < 20; k++) begin
            vt[k].raw = (k < 10) ? 3'b001 : 3'b000;
            vt[k].lvl = (k >= 6 && k <= 15);
            vt[k].prs = (k == 6);
            vt[k].rel = (k == 16);
        end
        exp3   = '{26, 31, 36, 41};
        exp4   = '{26, 34, 39, 44, 49};
        bounce = '{1, 0, 1, 1, 0, 1};

        // 1. clean press, table driven
        do_reset();
        for (int k = 0; k < 20; k++) begin
            raw = vt[k].raw;
            tick();
            check("t1_level", {31'd0, btn_level[0]}, {31'd0, vt[k].lvl});
            check("t1_press", {31'd0, btn_press[0]}, {31'd0, vt[k].prs});
            check("t1_release", {31'd0, btn_release[0]}, {31'd0, vt[k].rel});
        end

        // 2. bounce on button 1
        do_reset();
        press_n = 0; press_at = -1; long_n = 0;
        for (int k = 0; k < 36; k++) begin
            raw = (k < 6) ? {1'b0, bounce[k][0], 1'b0} : ((k < 25) ? 3'b010 : 3'b000);
            tick();
            if (btn_press[1]) begin press_n++; press_at = cyc; end
            if (btn_long[1]) long_n++;
        end
        check("t2_press_count", press_n, 1);
        check("t2_press_cycle", press_at, 11);
        check("t2_no_long", long_n, 0);

        // 3. long press and repeat on button 2
        do_reset();
        press_at = -1; long_n = 0; long_at = -1; rel_at = -1; rq.delete();
        for (int k = 0; k < 50; k++) begin
            raw = (k < 40) ? 3'b100 : 3'b000;
            tick();
            if (btn_press[2]) press_at = cyc;
            if (btn_long[2]) begin long_n++; long_at = cyc; end
            if (btn_repeat[2]) rq.push_back(cyc);
            if (btn_release[2]) rel_at = cyc;
        end
        check("t3_press_cycle", press_at, 6);
        check("t3_long_count", long_n, 1);
        check("t3_long_cycle", long_at, 26);
        check("t3_repeat_count", rq.size(), 4);
        for (int j = 0; j < 4 && j < rq.size(); j++) check("t3_repeat_cycle", rq[j], exp3[j]);
        check("t3_release_cycle", rel_at, 46);

        // 4. release glitch while in long-press
        do_reset();
        rel_n = 0; rel_at = -1; low_n = 0; rq.delete();
        for (int k = 0; k < 62; k++) begin
            raw = ((k < 28) || (k >= 30 && k < 50)) ? 3'b100 : 3'b000;
            tick();
            if (btn_repeat[2]) rq.push_back(cyc);
            if (btn_release[2]) begin rel_n++; rel_at = cyc; end
            if (cyc >= 6 && cyc <= 55 && !btn_level[2]) low_n++;
        end
        check("t4_level_held", low_n, 0);
        check("t4_release_count", rel_n, 1);
        check("t4_release_cycle", rel_at, 56);
        check("t4_repeat_count", rq.size(), 5);
        for (int j = 0; j < 5 && j < rq.size(); j++) check("t4_repeat_cycle", rq[j], exp4[j]);

        // 5. simultaneous buttons
        do_reset();
        pv = '0; rv = '0; press_n = 0; rel_n = 0;
        for (int k = 0; k < 32; k++) begin
            raw = (k < 10) ? 3'b111 : ((k < 20) ? 3'b101 : 3'b000);
            tick();
            if (btn_press != 0) press_n++;
            if (btn_release != 0) rel_n++;
            if (cyc == 6) pv = btn_press;
            if (cyc == 16) rv = btn_release;
            if (cyc == 26) check("t5_release_rest", btn_release, 3'b101);
        end
        check("t5_press_vec", pv, 3'b111);
        check("t5_release_vec", rv, 3'b010);
        check("t5_press_cycles", press_n, 1);
        check("t5_release_cycles", rel_n, 2);

        // 6. reset mid-hold with raw still high
        do_reset();
        press_at = -1; rel_n = 0;
        for (int k = 0; k < 22; k++) begin
            raw = 3'b001;
            rst = (k == 10);
            tick();
            if (cyc == 9) check("t6_level_before", {31'd0, btn_level[0]}, 32'd1);
            if (cyc == 10)
                check("t6_outputs_cleared",
                      {btn_level, btn_press, btn_release, btn_long, btn_repeat}, 32'd0);
            if (btn_release[0]) rel_n++;
            if (cyc > 10 && btn_press[0] && press_at < 0) press_at = cyc;
        end
        rst = 1'b0;
        check("t6_no_release", rel_n, 0);
        check("t6_repress_cycle", press_at, 17);

        // Random phase: slow and bouncy segments, occasional reset
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int p;
            p = (seg % 2 == 0) ? 2 : 30;
            for (int k = 0; k < 400; k++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 99) < p) raw[i] = ~raw[i];
                rst = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
